// File: rtl/uart_tx_frame_sched.sv
// Round-robin scheduler sharing one UART telemetry frame packer between NUM_CH producers.
// Each channel posts a word into a holding register; one frame is issued per grant, followed by an idle gap.
module uart_tx_frame_sched #(
    parameter int                NUM_CH         = 4,
    parameter logic [NUM_CH-1:0] TEST_MASK      = '0,
    parameter int                FRAME_BYTES    = 7,
    parameter int                GAP_CYCLES     = 16,
    parameter int                TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         ch_valid,
    input  logic [32*NUM_CH-1:0]      ch_data,
    input  logic                      tx_busy,
    input  logic                      tx_start_mon,
    output logic [31:0]               tx_float,
    output logic                      tx_valid,
    output logic                      test,
    output logic [$clog2(NUM_CH)-1:0] grant_id,
    output logic                      frame_active,
    output logic [NUM_CH-1:0]         ch_pending,
    output logic [NUM_CH-1:0]         overrun,
    input  logic                      overrun_clr,
    output logic                      timeout_err,
    output logic [1:0]                fsm_state
);

    localparam int GW = $clog2(NUM_CH);
    localparam int BW = $clog2(FRAME_BYTES + 1);
    localparam int CW = $clog2(GAP_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BW-1:0] LAST_BYTE = BW'(FRAME_BYTES - 1);
    localparam logic [CW-1:0] LAST_GAP  = CW'(GAP_CYCLES - 1);
    localparam logic [WW-1:0] LAST_WD   = WW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]          state;
    logic [31:0]         hold [NUM_CH];
    logic [GW-1:0]       last_grant;
    logic [BW-1:0]       byte_cnt;
    logic [CW-1:0]       gap_cnt;
    logic [WW-1:0]       wd_cnt;
    logic                seen_busy;
    logic                busy_q;

    logic                grant;
    logic [GW-1:0]       grant_ch;
    logic [GW-1:0]       cand;
    logic [NUM_CH-1:0]   grant_onehot;
    logic [NUM_CH-1:0]   ovr_evt;
    logic                progress;

    assign frame_active = (state != S_IDLE);
    assign fsm_state    = state;

    // Search starts just after the last winner so every pending channel is served in turn.
    always_comb begin
        grant        = 1'b0;
        grant_ch     = '0;
        cand         = '0;
        grant_onehot = '0;
        if (state == S_IDLE && enable) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                cand = GW'((int'(last_grant) + k) % NUM_CH);
                if (!grant && ch_pending[cand]) begin
                    grant    = 1'b1;
                    grant_ch = cand;
                end
            end
        end
        if (grant) grant_onehot = NUM_CH'(1) << grant_ch;
        ovr_evt  = ch_valid & ch_pending & ~grant_onehot;
        progress = tx_start_mon | (tx_busy ^ busy_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tx_float    <= '0;
            tx_valid    <= 1'b0;
            test        <= 1'b0;
            grant_id    <= '0;
            last_grant  <= GW'(NUM_CH - 1);
            ch_pending  <= '0;
            overrun     <= '0;
            timeout_err <= 1'b0;
            byte_cnt    <= '0;
            gap_cnt     <= '0;
            wd_cnt      <= '0;
            seen_busy   <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
        end else begin
            busy_q   <= tx_busy;
            tx_valid <= grant;
            // A post landing on the granted channel re-arms it; the old word is already captured.
            ch_pending <= (ch_pending & ~grant_onehot) | ch_valid;
            overrun    <= (overrun & ~{NUM_CH{overrun_clr}}) | ovr_evt;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_valid[i]) hold[i] <= ch_data[32*i +: 32];
            end
            if (overrun_clr) timeout_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (grant) begin
                        tx_float   <= hold[grant_ch];
                        test       <= TEST_MASK[grant_ch];
                        grant_id   <= grant_ch;
                        last_grant <= grant_ch;
                        byte_cnt   <= '0;
                        wd_cnt     <= '0;
                        state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_start_mon) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            seen_busy <= 1'b0;
                            state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (tx_busy) seen_busy <= 1'b1;
                    if (seen_busy && !tx_busy) begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end
                default: begin
                    if (gap_cnt == LAST_GAP) state <= S_IDLE;
                    else gap_cnt <= gap_cnt + 1'b1;
                end
            endcase

            // Watchdog overrides the frame FSM; a timeout wins over a concurrent clear.
            if (state == S_SEND || state == S_DRAIN) begin
                if (progress) begin
                    wd_cnt <= '0;
                end else if (wd_cnt == LAST_WD) begin
                    timeout_err <= 1'b1;
                    gap_cnt     <= '0;
                    state       <= S_GAP;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
        end
    end

endmodule
